// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types, default widths and the round-robin pick function
//            used by the data-memory arbiter and its round-robin core.
// Contents : arb_state_e    - arbiter lock state (IDLE / LOCKED)
//            DATA_W, ADDR_W - default data / byte-address widths
//            MAX_REQ        - largest supported requester count
//            REQ_IDX_W      - width of a requester index
//            next_rr()      - one-hot round-robin winner
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MAX_REQ   = 4;
  localparam int REQ_IDX_W = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // One-hot winner: the first set bit of valid, searching upward from
  // last+1 and wrapping. The search runs over all MAX_REQ slots; callers
  // with fewer requesters tie the unused upper valid bits to zero, which
  // yields exactly the modulo-N_REQ order because the skipped slots can
  // never win.
  function automatic logic [MAX_REQ-1:0] next_rr(
    input logic [MAX_REQ-1:0]   valid,
    input logic [REQ_IDX_W-1:0] last
  );
    logic [MAX_REQ-1:0]   w_grant;
    logic [REQ_IDX_W-1:0] w_idx;
    logic                 w_found;
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      w_idx = last + REQ_IDX_W'(i);   // wraps naturally at MAX_REQ
      if (!w_found && valid[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
    return w_grant;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Pure round-robin pick. Given a valid vector and the index of
//            the last granted requester, returns the one-hot winner (or zero
//            when nothing is valid). Holds no state of its own.
// Ports    : i_valid [N_REQ]     - candidate requesters
//            i_last  [REQ_IDX_W] - search starts at i_last+1 (mod N_REQ)
//            o_grant [N_REQ]     - one-hot winner, zero if no candidate
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]     i_valid,
  input  logic [REQ_IDX_W-1:0] i_last,
  output logic [N_REQ-1:0]     o_grant
);

  logic [MAX_REQ-1:0] w_valid_ext;
  logic [MAX_REQ-1:0] w_grant_ext;
  logic               w_unused_hi;

  always_comb begin
    w_valid_ext              = '0;
    w_valid_ext[N_REQ-1:0]   = i_valid;
  end

  assign w_grant_ext = next_rr(w_valid_ext, i_last);
  assign o_grant     = w_grant_ext[N_REQ-1:0];

  // Upper grant bits are always zero (their valid bits are tied low).
  assign w_unused_hi = |w_grant_ext;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port, word-addressed data memory between
//            N_REQ requesters (0 = CPU MEM stage, 1 = debug/DMA loader).
//            Round-robin arbitration with an optional bounded bus lock,
//            drives the memory's combinational-read / clocked-write port and
//            returns a registered response one cycle after each grant.
// Ports    : clk_i, rst_ni          - clock, async active-low reset
//            req_valid_i/lock/we    - per-requester request controls
//            req_addr_i/req_wdata_i - packed per-requester address / data
//            req_ready_o            - one-hot grant (acceptance this cycle)
//            rsp_valid_o/rsp_rdata_o- registered response
//            rsp_err_o              - range error (option only)
//            mem_we_o/a_o/wd_o/rd_i - memory port
// Options  : DMEM_ARB_RANGE_CHECK_EN - adds DEPTH_WORDS and rsp_err_o; an
//            access with word index >= DEPTH_WORDS does not write and
//            returns an error response with zero data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int N_REQ    = 2,
  parameter int DATA_W   = dmem_arb_pkg::DATA_W,
  parameter int ADDR_W   = dmem_arb_pkg::ADDR_W,
  parameter int MAX_HOLD = 4
`ifdef DMEM_ARB_RANGE_CHECK_EN
  ,
  parameter int DEPTH_WORDS = 64
`endif
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ-1:0]          req_lock_i,
  input  logic [N_REQ-1:0]          req_we_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
`ifdef DMEM_ARB_RANGE_CHECK_EN
  output logic [N_REQ-1:0]          rsp_err_o,
`endif
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_a_o,
  output logic [DATA_W-1:0]         mem_wd_o,
  input  logic [DATA_W-1:0]         mem_rd_i
);

  import dmem_arb_pkg::*;

  localparam int                   HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0]    C_MAX_HOLD = HOLD_W'(MAX_HOLD);
  localparam logic [REQ_IDX_W-1:0] C_LAST_RST = REQ_IDX_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [REQ_IDX_W-1:0]   r_owner;
  logic [REQ_IDX_W-1:0]   w_owner_nxt;
  logic [REQ_IDX_W-1:0]   r_last_grant;
  logic [REQ_IDX_W-1:0]   w_last_nxt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [HOLD_W-1:0]      w_hold_nxt;

  logic [N_REQ-1:0]       r_rsp_valid;
  logic [DATA_W-1:0]      r_rsp_rdata;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]       w_owner_oh;
  logic [N_REQ-1:0]       w_others;
  logic                   w_force_release;
  logic                   w_owner_keeps;
  logic [N_REQ-1:0]       w_rr_valid;
  logic [REQ_IDX_W-1:0]   w_rr_last;
  logic [N_REQ-1:0]       w_rr_grant;
  logic [N_REQ-1:0]       w_grant;
  logic                   w_accept;
  logic [REQ_IDX_W-1:0]   w_gidx;
  logic                   w_sel_we;
  logic                   w_sel_lock;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic                   w_oob;

  // Lock decode feeding the round-robin core. When the hold budget is spent
  // and someone else is waiting, the owner is masked out so the round-robin
  // search (starting after the owner) picks the next competitor.
  always_comb begin
    w_owner_oh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_owner_oh[k] = (r_owner == REQ_IDX_W'(k));
    end
    w_others        = req_valid_i & ~w_owner_oh;
    w_force_release = (r_state == LOCKED) && (r_hold_cnt == C_MAX_HOLD) && (|w_others);
    w_owner_keeps   = (r_state == LOCKED) && (|(req_valid_i & w_owner_oh)) && !w_force_release;
    w_rr_valid      = w_force_release ? w_others : req_valid_i;
    // In LOCKED the last acceptance was always the owner, so searching from
    // the owner is the same as searching from last_grant; stated explicitly.
    w_rr_last       = (r_state == LOCKED) ? r_owner : r_last_grant;
  end

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .i_valid (w_rr_valid),
    .i_last  (w_rr_last),
    .o_grant (w_rr_grant)
  );

  // --------------------------------------------------------------------------
  // Output decode: final grant and the selected requester's memory drive.
  // A grant is only ever given to a valid requester, so grant == acceptance.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant     = w_owner_keeps ? w_owner_oh : w_rr_grant;
    w_accept    = |w_grant;
    w_gidx      = '0;
    w_sel_we    = 1'b0;
    w_sel_lock  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant[k]) begin
        w_gidx      = REQ_IDX_W'(k);
        w_sel_we    = req_we_i[k];
        w_sel_lock  = req_lock_i[k];
        w_sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_W-3:0] C_DEPTH_IDX = (ADDR_W-2)'(DEPTH_WORDS);
  assign w_oob = w_accept && (w_sel_addr[ADDR_W-1:2] >= C_DEPTH_IDX);
`else
  assign w_oob = 1'b0;
`endif

  assign req_ready_o = w_grant;
  assign mem_a_o     = w_sel_addr;
  assign mem_wd_o    = w_sel_wdata;
  assign mem_we_o    = w_sel_we & ~w_oob;

  // --------------------------------------------------------------------------
  // Next-state logic.
  // Any acceptance with lock set makes the accepted requester the owner; a
  // repeat grant to the current owner extends the hold (saturating). Any
  // other outcome (no lock on acceptance, or no acceptance at all, which in
  // LOCKED means the owner dropped valid with nobody else waiting) unlocks.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = IDLE;
    w_owner_nxt = r_owner;
    w_hold_nxt  = '0;
    w_last_nxt  = r_last_grant;
    if (w_accept) begin
      w_last_nxt = w_gidx;
      if (w_sel_lock) begin
        w_state_nxt = LOCKED;
        if ((r_state == LOCKED) && (w_gidx == r_owner)) begin
          w_hold_nxt = (r_hold_cnt == C_MAX_HOLD) ? r_hold_cnt : r_hold_cnt + 1'b1;
        end else begin
          w_owner_nxt = w_gidx;
          w_hold_nxt  = HOLD_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_hold_cnt   <= '0;
      r_last_grant <= C_LAST_RST;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_last_grant <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Response register: read data is captured from the combinational memory
  // read in the acceptance cycle; writes and rejected accesses return zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      r_rsp_rdata <= (w_accept && !w_sel_we && !w_oob) ? mem_rd_i : '0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic [N_REQ-1:0] r_rsp_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_err <= '0;
    end else begin
      r_rsp_err <= w_oob ? w_grant : '0;
    end
  end

  assign rsp_err_o = r_rsp_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter. A driver applies directed
//            and random requests, predicts the grant from the arbitration
//            rules and pushes the expected response into a scoreboard; a
//            monitor pops and compares whenever a response is due or seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int N     = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int MH    = 4;
  localparam int DEPTH = 64;

  logic              clk_i  = 1'b0;
  logic              rst_ni = 1'b1;
  logic [N-1:0]      req_valid_i, req_lock_i, req_we_i;
  logic [N*AW-1:0]   req_addr_i;
  logic [N*DW-1:0]   req_wdata_i;
  logic [N-1:0]      req_ready_o, rsp_valid_o;
  logic [DW-1:0]     rsp_rdata_o;
  logic              mem_we_o;
  logic [AW-1:0]     mem_a_o;
  logic [DW-1:0]     mem_wd_o, mem_rd_i;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic [N-1:0]      rsp_err_o;
`endif

  dmem_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_HOLD (MH)
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    .DEPTH_WORDS (DEPTH)
`endif
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_lock_i  (req_lock_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
`ifdef DMEM_ARB_RANGE_CHECK_EN
    .rsp_err_o   (rsp_err_o),
`endif
    .mem_we_o    (mem_we_o),
    .mem_a_o     (mem_a_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory environment: combinational read, clocked write, reloaded with a
  // known pattern while reset is held.
  function automatic logic [DW-1:0] init_word(int i);
    return (DW'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  logic [DW-1:0] env_mem [DEPTH];
  assign mem_rd_i = env_mem[mem_a_o[7:2]];
  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
    end else if (mem_we_o) begin
      env_mem[mem_a_o[7:2]] <= mem_wd_o;
    end
  end

  // --------------------------------------------------------------------------
  // Counters, checker, scoreboard
  // --------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          who;
    logic [DW-1:0] rdata;
    bit          err;
    int          due;
  } exp_t;
  exp_t sb[$];

  // --------------------------------------------------------------------------
  // Reference model: arbitration rules in plain integer form
  // --------------------------------------------------------------------------
  bit            p_valid [N];
  bit            p_lock  [N];
  bit            p_we    [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_wdata [N];

  int            m_last, m_owner, m_hold;
  bit            m_locked;
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic model_reset();
    m_last = N - 1; m_owner = 0; m_hold = 0; m_locked = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
  endtask

  function automatic int model_grant();
    bit others = 0;
    bit excl   = 0;
    int start;
    for (int k = 0; k < N; k++) if (p_valid[k] && k != m_owner) others = 1;
    if (m_locked) begin
      excl = (m_hold == MH) && others;
      if (p_valid[m_owner] && !excl) return m_owner;
      start = m_owner;
    end else begin
      start = m_last;
    end
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (start + i) % N;
      if (p_valid[k] && !(excl && k == m_owner)) return k;
    end
    return -1;
  endfunction

  task automatic model_accept(input int g);
    m_last = g;
    if (p_lock[g]) begin
      if (m_locked && m_owner == g) begin
        if (m_hold < MH) m_hold++;
      end else begin
        m_locked = 1; m_owner = g; m_hold = 1;
      end
    end else begin
      m_locked = 0; m_hold = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic apply();
    for (int k = 0; k < N; k++) begin
      req_valid_i[k]             = p_valid[k];
      req_lock_i[k]              = p_lock[k];
      req_we_i[k]                = p_we[k];
      req_addr_i[k*AW +: AW]     = p_addr[k];
      req_wdata_i[k*DW +: DW]    = p_wdata[k];
    end
  endtask

  task automatic set_req(input int k, input bit v, input bit lk, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[k] = v; p_lock[k] = lk; p_we[k] = we; p_addr[k] = a; p_wdata[k] = d;
  endtask

  task automatic clear_reqs();
    for (int k = 0; k < N; k++) set_req(k, 0, 0, 0, '0, '0);
  endtask

  // One cycle: inputs already applied just after a rising edge. At the
  // falling edge, predict and compare the combinational outputs and queue
  // the expected response; return just after the next rising edge.
  task automatic step(output int g, output logic [N-1:0] rdy, output logic we_seen);
    int   word;
    bit   oob;
    logic [DW-1:0] exp_rd;
    @(negedge clk_i);
    g       = model_grant();
    rdy     = req_ready_o;
    we_seen = mem_we_o;
    word    = 0;
    oob     = 0;
    if (g >= 0) begin
      word = int'(p_addr[g][AW-1:2]);
`ifdef DMEM_ARB_RANGE_CHECK_EN
      oob  = (word >= DEPTH);
`endif
    end
    chk("ready",  req_ready_o, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("mem_we", mem_we_o,    (g >= 0) ? 64'(p_we[g] && !oob) : 64'd0);
    chk("mem_a",  mem_a_o,     (g >= 0) ? 64'(p_addr[g]) : 64'd0);
    chk("mem_wd", mem_wd_o,    (g >= 0) ? 64'(p_wdata[g]) : 64'd0);
    if (g >= 0) begin
      exp_rd = (p_we[g] || oob) ? '0 : ref_mem[word];
      sb.push_back('{who: g, rdata: exp_rd, err: oob, due: cyc + 1});
      if (p_we[g] && !oob) ref_mem[word] = p_wdata[g];
      model_accept(g);
    end else begin
      m_locked = 0; m_hold = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Asserts reset (possibly mid-transaction), checks the reset outputs,
  // then releases reset on a falling edge.
  task automatic do_reset();
    rst_ni = 1'b0;
    sb.delete();
    clear_reqs();
    apply();
    #1;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_ready_idle", req_ready_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    chk("rst_rsp_err", rsp_err_o, 0);
`endif
    // Requester 0 has first priority straight out of reset.
    set_req(0, 1, 0, 0, 32'h0, '0);
    set_req(1, 1, 0, 0, 32'h4, '0);
    apply();
    #1;
    chk("rst_ready_prio0", req_ready_o, 1);
    clear_reqs();
    apply();
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk_i) begin
    exp_t e;
    #1;
    if (rsp_valid_o != '0) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL rsp_spurious: got rsp_valid %0b expected none (cycle %0d)", rsp_valid_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid_o, 64'd1 << e.who);
        chk("rsp_rdata", rsp_rdata_o, e.rdata);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        chk("rsp_err", rsp_err_o, e.err ? (64'd1 << e.who) : 64'd0);
`endif
      end
    end else if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL rsp_missing: got rsp_valid 0 expected %0b (cycle %0d)", 1 << e.who, cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int            g;
    logic [N-1:0]  rdy;
    logic          wes;
    int            wcnt [N];
    logic [N-1:0]  exp_seq [5];

    clear_reqs();
    apply();
    #2;
    do_reset();

    // Write then read back the same word.
    set_req(0, 1, 0, 1, 32'h10, 32'hDEADBEEF);
    apply();
    step(g, rdy, wes);
    chk("tp1_wr_ready", rdy, 2'b01);
    set_req(0, 1, 0, 0, 32'h10, '0);
    apply();
    step(g, rdy, wes);
    chk("tp1_rd_ready", rdy, 2'b01);
    chk("tp1_rd_rsp_valid", rsp_valid_o, 2'b01);
    chk("tp1_rd_rdata", rsp_rdata_o, 32'hDEADBEEF);
    clear_reqs();
    apply();
    step(g, rdy, wes);

    // Continuous contention without lock alternates.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, 0, 32'(4 * i), '0);
      set_req(1, 1, 0, 0, 32'(4 * i + 32), '0);
      apply();
      step(g, rdy, wes);
      chk("tp2_alternate", rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Locked owner yields after MAX_HOLD grants when someone waits.
    do_reset();
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      set_req(1, 1, 1, 0, 32'h40, '0);
      set_req(0, (i > 0), 0, 0, 32'h44, '0);
      apply();
      step(g, rdy, wes);
      chk("tp3_hold_seq", rdy, exp_seq[i]);
    end

    // Lock with no competitor is unbounded; the saturated count then yields
    // immediately once a competitor appears.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_req(1, 1, 1, 1, 32'h80, 32'(i));
      apply();
      step(g, rdy, wes);
      chk("tp4_unbounded", rdy, 2'b10);
    end
    set_req(0, 1, 0, 0, 32'h80, '0);
    apply();
    step(g, rdy, wes);
    chk("tp4_saturated_yield", rdy, 2'b01);

    // Reset mid-lock, the cycle after acceptance.
    do_reset();
    set_req(1, 1, 1, 0, 32'h20, '0);
    apply();
    step(g, rdy, wes);
    chk("tp5_pre_rsp_valid", rsp_valid_o, 2'b10);
    do_reset();
    set_req(0, 1, 0, 0, 32'h24, '0);
    set_req(1, 1, 1, 0, 32'h28, '0);
    apply();
    step(g, rdy, wes);
    chk("tp5_post_rst_grant", rdy, 2'b01);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    // Out-of-range write: suppressed, flagged, memory untouched.
    do_reset();
    set_req(0, 1, 0, 1, 32'h100, 32'hCAFEF00D);
    apply();
    step(g, rdy, wes);
    chk("tp6_oob_mem_we", wes, 0);
    chk("tp6_oob_err", rsp_err_o, 2'b01);
    chk("tp6_oob_rdata", rsp_rdata_o, 0);
    set_req(0, 1, 0, 0, 32'h0, '0);
    apply();
    step(g, rdy, wes);
    chk("tp6_word0_kept", rsp_rdata_o, init_word(0));
`endif

    // Random traffic: requests held until accepted, random lock/we/address.
    do_reset();
    g = -1;
    for (int k = 0; k < N; k++) wcnt[k] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!p_valid[k] || g == k) begin
          set_req(k, ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 40),
                  1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00},
                  $urandom);
        end
      end
      apply();
      step(g, rdy, wes);
      for (int k = 0; k < N; k++) begin
        if (p_valid[k] && g != k) begin
          wcnt[k]++;
          chk("wait_bound", (wcnt[k] > MH + N - 1), 0);
        end else begin
          wcnt[k] = 0;
        end
      end
    end

    clear_reqs();
    apply();
    for (int i = 0; i < 3; i++) step(g, rdy, wes);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
